// File: rtl/hyst_edge_stream.sv
// Streaming dual-threshold classifier with weak-edge connection over a 3x3 class window.
// Two 2-bit line buffers feed the window; output register carries full ready/valid backpressure.
module hyst_edge_stream #(
    parameter int              IMG_W    = 1024,
    parameter int              IMG_H    = 768,
    parameter int              MAG_W    = 12,
    parameter int              TH_W     = 8,
    parameter int              OUT_W    = 8,
    parameter logic [OUT_W-1:0] EDGE_VAL = '0,
    parameter logic [OUT_W-1:0] BG_VAL   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [MAG_W-1:0] s_data,
    input  logic             s_user,
    input  logic             s_last,
    input  logic [TH_W-1:0]  gth,
    input  logic [TH_W-1:0]  gtl,
    input  logic [1:0]       mode,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_user,
    output logic             m_last,
    output logic             err_sof,
    output logic             err_eol,
    output logic             busy
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0]    X_LAST     = XW'(IMG_W - 1);
    localparam logic [YW-1:0]    Y_LAST     = YW'(IMG_H - 1);
    localparam logic [1:0]       C_NONE     = 2'd0;
    localparam logic [1:0]       C_WEAK     = 2'd1;
    localparam logic [1:0]       C_STRONG   = 2'd2;
    localparam logic [OUT_W-1:0] DBG_WEAK   = OUT_W'(1) << (OUT_W - 1);
    localparam logic [OUT_W-1:0] DBG_STRONG = '1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

    state_t                 state_q, state_d;
    logic [XW-1:0]          x_q, x_d, ox_q, ox_d;
    logic [YW-1:0]          y_q, y_d, oy_q, oy_d;
    logic [TH_W-1:0]        gth_q, gth_d, gtl_q, gtl_d;
    logic [1:0]             mode_q, mode_d;
    logic [2:0][2:0][1:0]   win_q, win_d, win_shift;   // [column][row], row 0 is the top
    logic                   m_valid_q, m_valid_d, m_user_q, m_user_d, m_last_q, m_last_d;
    logic [OUT_W-1:0]       m_data_q, m_data_d;
    logic                   err_sof_q, err_sof_d, err_eol_q, err_eol_d;

    logic [1:0]             lb0_mem [IMG_W];
    logic [1:0]             lb1_mem [IMG_W];
    logic [1:0]             rd0_q, rd1_q;

    logic                   out_free, accept, sof_acc, frame_acc, flush_step, emit;
    logic [TH_W-1:0]        gth_eff, gtl_eff, gtl_clip;
    logic [1:0]             cls_in, center;
    logic [XW-1:0]          px;
    logic [2:0][1:0]        new_col;
    logic [8:0]             nb_strong;
    logic [OUT_W-1:0]       pix_val;

    assign out_free   = ~m_valid_q | m_ready;
    assign s_ready    = (state_q != S_FLUSH) & out_free;
    assign accept     = s_valid & s_ready;
    assign sof_acc    = accept & s_user;
    assign frame_acc  = accept & (s_user | (state_q != S_IDLE));
    assign flush_step = (state_q == S_FLUSH) & out_free;
    assign emit       = (frame_acc & ~sof_acc & (state_q == S_RUN)) | flush_step;
    assign px         = sof_acc ? '0 : x_q;

    // A new frame's first pixel must be classified with the thresholds it brings along.
    assign gth_eff  = sof_acc ? gth : gth_q;
    assign gtl_eff  = sof_acc ? gtl : gtl_q;
    assign gtl_clip = (gtl_eff > gth_eff) ? gth_eff : gtl_eff;

    always_comb begin
        cls_in = C_NONE;
        if (s_data >= MAG_W'(gth_eff))
            cls_in = C_STRONG;
        else if (s_data >= MAG_W'(gtl_clip))
            cls_in = C_WEAK;
    end

    assign new_col   = {flush_step ? C_NONE : cls_in, rd0_q, rd1_q};
    assign win_shift = {new_col, win_q[2], win_q[1]};
    assign center    = win_shift[1][1];

    // Taps outside the frame are masked by output position, which also hides stale buffer data.
    for (genvar gi = 0; gi < 9; gi++) begin : g_tap
        localparam int TC = gi / 3;
        localparam int TR = gi % 3;
        if (gi == 4) begin : g_center
            assign nb_strong[gi] = 1'b0;
        end else begin : g_nb
            localparam bit LEFT  = (TC == 0);
            localparam bit RIGHT = (TC == 2);
            localparam bit TOP   = (TR == 0);
            localparam bit BOT   = (TR == 2);
            assign nb_strong[gi] = (win_shift[TC][TR] == C_STRONG)
                                 && !(LEFT  && (ox_q == '0))
                                 && !(RIGHT && (ox_q == X_LAST))
                                 && !(TOP   && (oy_q == '0))
                                 && !(BOT   && (oy_q == Y_LAST));
        end
    end

    always_comb begin
        pix_val = BG_VAL;
        case (mode_q)
            2'd1:    pix_val = (center == C_STRONG) ? DBG_STRONG :
                               (center == C_WEAK)   ? DBG_WEAK : '0;
            2'd2:    pix_val = (center == C_STRONG) ? EDGE_VAL : BG_VAL;
            default: pix_val = ((center == C_STRONG) || ((center == C_WEAK) && (|nb_strong)))
                               ? EDGE_VAL : BG_VAL;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        gth_d     = gth_q;
        gtl_d     = gtl_q;
        mode_d    = mode_q;
        win_d     = (frame_acc | flush_step) ? win_shift : win_q;
        m_valid_d = emit | (m_valid_q & ~m_ready);
        m_data_d  = m_data_q;
        m_user_d  = m_user_q;
        m_last_d  = m_last_q;
        err_sof_d = 1'b0;
        err_eol_d = frame_acc & (s_last ^ (px == X_LAST));

        if (emit) begin
            m_data_d = pix_val;
            m_user_d = (ox_q == '0) && (oy_q == '0);
            m_last_d = (ox_q == X_LAST);
            ox_d     = (ox_q == X_LAST) ? '0 : ox_q + 1'b1;
            if (ox_q == X_LAST)
                oy_d = (oy_q == Y_LAST) ? '0 : oy_q + 1'b1;
        end

        if (sof_acc) begin
            err_sof_d = (state_q != S_IDLE);
            state_d   = S_FILL;
            x_d       = XW'(1);
            y_d       = '0;
            ox_d      = '0;
            oy_d      = '0;
            gth_d     = gth;
            gtl_d     = gtl;
            mode_d    = mode;
        end else if (accept && (state_q == S_IDLE)) begin
            err_sof_d = 1'b1;
        end else if (frame_acc || flush_step) begin
            // Flush keeps walking the column so the prefetched line-buffer taps stay aligned.
            x_d = (x_q == X_LAST) ? '0 : x_q + 1'b1;
            if (x_q == X_LAST)
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            if ((state_q == S_FILL) && (x_q == '0) && (y_q == YW'(1)))
                state_d = S_RUN;
            if ((state_q == S_RUN) && (x_q == X_LAST) && (y_q == Y_LAST))
                state_d = S_FLUSH;
            if (flush_step && (ox_q == X_LAST) && (oy_q == Y_LAST)) begin
                state_d = S_IDLE;
                x_d     = '0;
                y_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            gth_q     <= '0;
            gtl_q     <= '0;
            mode_q    <= '0;
            win_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= 1'b0;
            m_last_q  <= 1'b0;
            err_sof_q <= 1'b0;
            err_eol_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            gth_q     <= gth_d;
            gtl_q     <= gtl_d;
            mode_q    <= mode_d;
            win_q     <= win_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_user_q  <= m_user_d;
            m_last_q  <= m_last_d;
            err_sof_q <= err_sof_d;
            err_eol_q <= err_eol_d;
        end
    end

    // Registered read of the next column; it never collides with the write, which targets px.
    always_ff @(posedge clk) begin
        if (frame_acc) begin
            lb0_mem[px] <= cls_in;
            lb1_mem[px] <= rd0_q;
        end
        rd0_q <= lb0_mem[x_d];
        rd1_q <= lb1_mem[x_d];
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_user  = m_user_q;
    assign m_last  = m_last_q;
    assign err_sof = err_sof_q;
    assign err_eol = err_eol_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_hyst_edge_stream.sv
// Bench for hyst_edge_stream on a 4x3 image: directed and random frames against an
// arithmetic reference of the classify/connect rules, with backpressure, SOF/EOL errors and reset.
module tb_hyst_edge_stream;
    localparam int W = 4;
    localparam int H = 3;
    localparam int NPIX = W * H;
    localparam int EDGE = 0;
    localparam int BG = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, s_user, s_last;
    logic [11:0] s_data;
    logic [7:0]  gth, gtl;
    logic [1:0]  mode;
    logic        m_valid, m_ready, m_user, m_last;
    logic [7:0]  m_data;
    logic        err_sof, err_eol, busy;

    hyst_edge_stream #(.IMG_W(W), .IMG_H(H), .MAG_W(12), .TH_W(8), .OUT_W(8),
                       .EDGE_VAL(8'd0), .BG_VAL(8'd255)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_user(s_user), .s_last(s_last), .gth(gth), .gtl(gtl), .mode(mode),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_user(m_user),
        .m_last(m_last), .err_sof(err_sof), .err_eol(err_eol), .busy(busy));

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          err_sof_cnt = 0;
    int          err_eol_cnt = 0;
    bit          bp = 1'b0;
    bit          prev_stall = 1'b0;
    logic [9:0]  prev_out;
    logic [9:0]  got_q[$];
    int          mags[NPIX];
    int          exp_d[NPIX];
    int          old_exp[NPIX];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cls_of(input int m, input int hi, input int lo);
        int l;
        l = (lo > hi) ? hi : lo;
        if (m >= hi) return 2;
        if (m >= l) return 1;
        return 0;
    endfunction

    // Reference: each output is {data, user, last} for the pixel at the same raster index.
    task automatic build_exp(input int hi, input int lo, input int md);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int c, v;
                bit nb;
                c = cls_of(mags[y*W+x], hi, lo);
                nb = 1'b0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if ((dx != 0 || dy != 0) && x+dx >= 0 && x+dx < W && y+dy >= 0 && y+dy < H)
                            if (cls_of(mags[(y+dy)*W+x+dx], hi, lo) == 2) nb = 1'b1;
                case (md)
                    1: v = (c == 0) ? 0 : (c == 1) ? 128 : 255;
                    2: v = (c == 2) ? EDGE : BG;
                    default: v = (c == 2 || (c == 1 && nb)) ? EDGE : BG;
                endcase
                exp_d[y*W+x] = (v << 2) | (((y == 0 && x == 0) ? 1 : 0) << 1) | ((x == W-1) ? 1 : 0);
            end
        end
    endtask

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    chk("hold_while_stalled", int'({m_valid, m_data, m_user, m_last}), int'({1'b1, prev_out}));
                if (m_valid && !m_ready)
                    chk("no_accept_while_stalled", int'(s_valid & s_ready), 0);
                if (m_valid && m_ready) got_q.push_back({m_data, m_user, m_last});
                if (err_sof) err_sof_cnt++;
                if (err_eol) err_eol_cnt++;
                prev_stall = m_valid && !m_ready;
                prev_out = {m_data, m_user, m_last};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic send_pix(input int mag, input bit user, input bit last);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        s_valid = 1'b1; s_data = 12'(mag); s_user = user; s_last = last;
        while (!done && t <= 500) begin
            @(negedge clk);
            done = s_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!done) chk("accept_timeout", t, 0);
        s_valid = 1'b0; s_user = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input bit gaps, input bit bad_last, input bit scramble, input int npix);
        for (int i = 0; i < npix; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_pix(mags[i], i == 0, (i % W == W-1) || (bad_last && i == W + 2));
            if (scramble && i == 0) begin
                gth = 8'($urandom); gtl = 8'($urandom); mode = 2'($urandom);
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(posedge clk);
        #2;
        while ((busy || m_valid) && t < 2000) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("drain_idle", int'(busy | m_valid), 0);
    endtask

    task automatic check_frame(input string tag, input int offset);
        drain();
        chk({tag, "_count"}, got_q.size(), offset + NPIX);
        for (int i = 0; i < NPIX; i++)
            if (offset + i < got_q.size())
                chk($sformatf("%s[%0d]", tag, i), int'(got_q[offset+i]), exp_d[i]);
    endtask

    task automatic rand_mags(input bit tri_level);
        for (int i = 0; i < NPIX; i++) begin
            int r;
            r = $urandom_range(0, 2);
            mags[i] = tri_level ? ((r == 0) ? 10 : (r == 1) ? 60 : 120) : int'($urandom_range(0, 300));
        end
    endtask

    initial begin
        int s0, e0;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_user = 1'b0; s_last = 1'b0;
        gth = 8'd100; gtl = 8'd50; mode = 2'd0;
        #2;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_m_user", int'(m_user), 0);
        chk("rst_m_last", int'(m_last), 0);
        chk("rst_err_sof", int'(err_sof), 0);
        chk("rst_err_eol", int'(err_eol), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NPIX; i++) mags[i] = 10;
        mags[5] = 120; mags[6] = 60;
        build_exp(100, 50, 0);
        send_frame(0, 0, 0, NPIX);
        check_frame("binary", 0);
        got_q.delete();

        for (int i = 0; i < NPIX; i++) mags[i] = 10;
        mags[6] = 60; mags[3] = 60; mags[4] = 120;
        build_exp(100, 50, 0);
        send_frame(0, 0, 0, NPIX);
        check_frame("isolated_weak", 0);
        got_q.delete();
        chk("eol_none_so_far", err_eol_cnt, 0);

        rand_mags(1);
        gth = 8'd100; gtl = 8'd120; mode = 2'd1;
        build_exp(100, 120, 1);
        send_frame(0, 0, 0, NPIX);
        check_frame("mode1_gtl_hi", 0);
        got_q.delete();
        gtl = 8'd50;
        build_exp(100, 50, 1);
        send_frame(0, 0, 1, NPIX);
        check_frame("mode1_gtl_lo", 0);
        got_q.delete();

        bp = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int hi, lo;
            rand_mags(k[0]);
            hi = $urandom_range(60, 200);
            lo = $urandom_range(20, 150);
            gth = 8'(hi); gtl = 8'(lo); mode = 2'(k);
            build_exp(hi, lo, k);
            send_frame(1, 0, k[1], NPIX);
            check_frame($sformatf("bp_mode%0d", k), 0);
            got_q.delete();
        end
        bp = 1'b0;

        gth = 8'd100; gtl = 8'd50; mode = 2'd0;
        rand_mags(1);
        build_exp(100, 50, 0);
        e0 = err_eol_cnt;
        send_frame(0, 1, 0, NPIX);
        check_frame("eol_frame", 0);
        got_q.delete();
        chk("eol_single_pulse", err_eol_cnt - e0, 1);

        s0 = err_sof_cnt;
        send_pix(77, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_drop_sof", err_sof_cnt - s0, 1);
        chk("idle_drop_no_output", got_q.size(), 0);
        chk("idle_drop_not_busy", int'(busy), 0);

        s0 = err_sof_cnt;
        rand_mags(0);
        send_frame(0, 0, 0, 5);
        rand_mags(1);
        build_exp(100, 50, 0);
        send_frame(0, 0, 0, NPIX);
        check_frame("sof_abort5", 0);
        got_q.delete();
        chk("sof_abort5_pulse", err_sof_cnt - s0, 1);

        s0 = err_sof_cnt;
        rand_mags(1);
        build_exp(100, 50, 0);
        old_exp = exp_d;
        send_frame(0, 0, 0, 8);
        rand_mags(1);
        build_exp(100, 50, 0);
        send_frame(0, 0, 0, NPIX);
        check_frame("sof_abort8", 3);
        for (int i = 0; i < 3; i++)
            if (i < got_q.size()) chk($sformatf("sof_abort8_old[%0d]", i), int'(got_q[i]), old_exp[i]);
        got_q.delete();
        chk("sof_abort8_pulse", err_sof_cnt - s0, 1);

        rand_mags(0);
        send_frame(0, 0, 0, NPIX);
        chk("busy_in_flush", int'(busy), 1);
        #1; rst = 1'b1;
        #1;
        chk("flush_rst_m_valid", int'(m_valid), 0);
        chk("flush_rst_busy", int'(busy), 0);
        @(posedge clk); #1; rst = 1'b0;
        got_q.delete();
        @(posedge clk); #1;
        rand_mags(1);
        build_exp(100, 50, 0);
        send_frame(0, 0, 0, NPIX);
        check_frame("after_reset", 0);
        got_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hyst_edge_stream.md
Name: hyst_edge_stream

Overview:
- Parameterised successor to the single-image dual-threshold/weak-edge-connect stage of the Canny chain.
- Sits after NMS. Consumes one NMS magnitude per pixel over a ready/valid stream and classifies it strong, weak or none. Builds a 3x3 class window from internal line buffers and emits one edge pixel per input pixel over an AXI-stream-style output with full backpressure.
- Adds over the previous generation: frame and line sideband, border masking, end-of-frame flush, a selectable output mode, and SOF error recovery.

Parameters:
- IMG_W, 1024, pixels per line (>=3).
- IMG_H, 768, lines per frame (>=3).
- MAG_W, 12, NMS magnitude width.
- TH_W, 8, threshold width (<= MAG_W); compared zero-extended.
- OUT_W, 8, output pixel width.
- EDGE_VAL, 0, output code for an edge pixel.
- BG_VAL, 2**OUT_W-1, output code for a background pixel.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_valid  in  1  input magnitude valid.
- s_ready  out  1  block accepts input.
- s_data  in  MAG_W  NMS magnitude.
- s_user  in  1  start of frame; marks pixel (0,0).
- s_last  in  1  end of line, checked only.
- gth  in  TH_W  high threshold.
- gtl  in  TH_W  low threshold.
- mode  in  2  0/3 = hysteresis edge; 1 = class debug; 2 = strong only.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream ready.
- m_data  out  OUT_W  output pixel.
- m_user  out  1  first output pixel of frame.
- m_last  out  1  last pixel of an output line.
- err_sof  out  1  one-cycle pulse on unexpected or missing SOF.
- err_eol  out  1  one-cycle pulse on s_last mismatch.
- busy  out  1  frame in progress (state != IDLE).

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE, counters are cleared and the output register is empty. Line-buffer contents are not cleared; border masking makes stale contents invisible.
- One-clock async-high reset only; no synchronous clear.
- Accept = s_valid & s_ready.
- s_ready = (state is IDLE/FILL/RUN) & (~m_valid | m_ready).
- m_data, m_user and m_last hold stable while m_valid & ~m_ready.
- Classification: strong if s_data >= gth; weak if gtl <= s_data < gth; else none.
  - If gtl > gth, gtl is treated as gth, so no weak class exists.
  - gth, gtl and mode are sampled on the SOF accept and held for the whole frame.
- Storage: two line buffers of IMG_W x 2 bits plus a 3x3 class window. The window shifts only on accept or on a flush step.
- Ordering: input and output follow the same raster order.
  - Output pixel n (n = y*IMG_W + x) is emitted after input pixel n+IMG_W+1 is accepted.
  - Outputs n >= IMG_W*IMG_H-IMG_W-1 are emitted in FLUSH.
  - Output count per frame equals IMG_W*IMG_H exactly.
- Border: window taps outside the image (x-1<0, x+1>=IMG_W, y-1<0, y+1>=IMG_H) read as none. There is no wrap between adjacent lines.
- Output value by mode:
  - mode 0/3: strong -> EDGE_VAL; weak with >=1 strong 8-neighbour -> EDGE_VAL; otherwise BG_VAL.
  - mode 1: none -> 0, weak -> 2**(OUT_W-1), strong -> 2**OUT_W-1.
  - mode 2: strong -> EDGE_VAL, otherwise BG_VAL.
- Sideband: m_user=1 on output n=0. m_last=1 on output x=IMG_W-1.
- FSM:
  - IDLE: inputs with s_user=0 are accepted and dropped, with an err_sof pulse on each. An accept with s_user=1 moves to FILL.
  - FILL: accept inputs without output until IMG_W+1 pixels are taken, then go to RUN.
  - RUN: each accept produces one output. After input pixel IMG_W*IMG_H-1, go to FLUSH.
  - FLUSH: s_ready=0. Emit the remaining IMG_W+1 outputs, one per cycle when the output register is free, with padding taps as none. Then go to IDLE.
- Simultaneous events:
  - An accept with s_user=1 in FILL or RUN pulses err_sof and aborts the current frame; outputs not yet emitted are discarded. The held output register still completes its handshake. That pixel starts a new frame in FILL.
  - s_last != (x==IMG_W-1) pulses err_eol. Internal counters stay authoritative and are not resynchronised.
- Throughput: 1 pixel/clock sustained with m_ready=1. No bubbles are introduced except during FLUSH.
- Widths: the column counter is clog2(IMG_W) bits and the row counter clog2(IMG_H) bits; both wrap to 0 at frame end.

Test Plan:
- Binary pattern (IMG_W=4, IMG_H=3, gth=100, gtl=50, mode 0): frame of all 10 except pixel (1,1)=120 and (2,1)=60 -> 12 outputs. (1,1) and (2,1) = 0; all others 255. m_user on output 0; m_last on outputs 3, 7, 11.
- Isolated weak: the same frame with (1,1)=10 -> (2,1)=255. A weak pixel with no strong neighbour is not connected. Right-edge weak (3,0)=60 with strong (0,1) -> 255, proving there is no line wrap.
- Backpressure: random m_ready at 30% -> output sequence is bit-identical to the m_ready=1 run. m_data is stable while stalled. No input is accepted while m_valid & ~m_ready.
- Mode 1, and gtl=120 > gth=100 -> magnitudes 10/60/120 map to 0/0/255. With gtl=50: 0/128/255.
- SOF recovery: assert s_user at input 5 of a frame -> err_sof pulse and the old frame is aborted. The next 12 outputs match a clean frame with m_user on the first. s_last at x=2 -> single err_eol pulse with output unchanged.
- Async reset asserted mid-FLUSH -> m_valid=0, busy=0 within the reset cycle. The next clean frame is correct.
